// File: rtl/rand_conditioner.sv
// rand_conditioner: von Neumann debias, word packing and repetition health check for a raw random bit stream
module rand_conditioner #(
  parameter int OUT_W        = 4,
  parameter int USE_VN       = 1,
  parameter int REPEAT_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_bit,
  input  logic             sample_en,
  input  logic             rand_ready,
  output logic [OUT_W-1:0] rand_data,
  output logic             rand_valid,
  output logic             stuck
);
  localparam int CW = $clog2(OUT_W + 1);
  localparam int RW = $clog2(REPEAT_LIMIT + 1);
  typedef enum logic {FIRST, SECOND} pair_t;
  pair_t            state, state_nxt;
  logic             a_bit, a_nxt;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [RW-1:0]    run, run_nxt;
  logic             prev, full, free, xfer, take, accept, bit_in;
  // Pair extraction, accumulator advance and run-length tracking
  always_comb begin
    full      = cnt == CW'(OUT_W);
    free      = !rand_valid || rand_ready;
    xfer      = full && free;
    take      = sample_en && !(full && !free);
    state_nxt = state;
    a_nxt     = a_bit;
    accept    = 1'b0;
    bit_in    = raw_bit;
    if (take) begin
      if (USE_VN == 0) accept = 1'b1;
      else if (state == FIRST) begin
        a_nxt     = raw_bit;
        state_nxt = SECOND;
      end else begin
        accept    = a_bit != raw_bit;
        bit_in    = a_bit;
        state_nxt = FIRST;
      end
    end
    acc_nxt = accept ? {acc[OUT_W-2:0], bit_in} : acc;
    cnt_nxt = (xfer ? '0 : cnt) + CW'(accept);
    run_nxt = !sample_en ? run :
              (run != '0 && raw_bit == prev) ? (run == RW'(REPEAT_LIMIT) ? run : run + RW'(1)) : RW'(1);
  end
  // Pair FSM state register; a stuck source parks it in FIRST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FIRST;
      a_bit <= 1'b0;
    end else begin
      state <= stuck ? FIRST : state_nxt;
      a_bit <= stuck ? 1'b0 : a_nxt;
    end
  end
  // Accumulator, output register and sticky health alarm
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      cnt        <= '0;
      run        <= '0;
      prev       <= 1'b0;
      rand_data  <= '0;
      rand_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      run   <= run_nxt;
      prev  <= sample_en ? raw_bit : prev;
      stuck <= stuck || run == RW'(REPEAT_LIMIT);
      if (stuck) begin
        acc        <= '0;
        cnt        <= '0;
        rand_valid <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (xfer) begin
          rand_data  <= acc;
          rand_valid <= 1'b1;
        end else if (rand_ready) rand_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rand_conditioner.sv
// tb_rand_conditioner: scoreboard bench for rand_conditioner in debiased and raw modes
module tb_rand_conditioner;
  logic clk, reset, raw_bit, sen_v, sen_r, rdy_v, rdy_r;
  logic [3:0] data_v, data_r;
  logic val_v, val_r, stk_v, stk_r;
  int total = 0, bad = 0;
  logic [3:0] qv[$], qr[$];
  logic pvv, phv, pvr, phr;
  logic [3:0] pdv, pdr;

  rand_conditioner #(.OUT_W(4), .USE_VN(1), .REPEAT_LIMIT(8)) dut_v (
    .clk(clk), .reset(reset), .raw_bit(raw_bit), .sample_en(sen_v), .rand_ready(rdy_v),
    .rand_data(data_v), .rand_valid(val_v), .stuck(stk_v));
  rand_conditioner #(.OUT_W(4), .USE_VN(0), .REPEAT_LIMIT(8)) dut_r (
    .clk(clk), .reset(reset), .raw_bit(raw_bit), .sample_en(sen_r), .rand_ready(rdy_r),
    .rand_data(data_r), .rand_valid(val_r), .stuck(stk_r));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) pvv = 0;
    else begin
      if (pvv && !phv) begin
        chk("v_hold_valid", val_v, 1);
        chk("v_hold_data", data_v, pdv);
      end
      if (val_v && rdy_v) begin
        if (qv.size() == 0) begin
          total++; bad++;
          $display("FAIL v_unexpected_word got=%0h exp=none", data_v);
        end else chk("v_word", data_v, qv.pop_front());
      end
      pvv = val_v; pdv = data_v; phv = val_v && rdy_v;
    end
  end

  always @(negedge clk) begin
    if (!reset) pvr = 0;
    else begin
      if (pvr && !phr) begin
        chk("r_hold_valid", val_r, 1);
        chk("r_hold_data", data_r, pdr);
      end
      if (val_r && rdy_r) begin
        if (qr.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected_word got=%0h exp=none", data_r);
        end else chk("r_word", data_r, qr.pop_front());
      end
      pvr = val_r; pdr = data_r; phr = val_r && rdy_r;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic samp_v(input logic b);
    raw_bit = b; sen_v = 1;
    @(posedge clk); #1;
    sen_v = 0;
  endtask

  task automatic samp_r(input logic b);
    raw_bit = b; sen_r = 1;
    @(posedge clk); #1;
    sen_r = 0;
  endtask

  task automatic vnb(input logic b);
    samp_v(b);
    samp_v(!b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] s2;
    logic [7:0] s5;
    reset = 0; raw_bit = 0; sen_v = 0; sen_r = 0; rdy_v = 0; rdy_r = 0;
    tick(2);
    chk("rst_valid", val_v, 0);
    chk("rst_data", data_v, 0);
    chk("rst_stuck", stk_v, 0);
    chk("rst_valid_r", val_r, 0);
    reset = 1;
    tick(1);
    // debiased word, immediate consumer
    rdy_v = 1;
    qv.push_back(4'b1010);
    s2 = 12'b10_01_11_10_00_01;
    for (int i = 11; i >= 0; i--) samp_v(s2[i]);
    chk("t2_latency_early", val_v, 0);
    tick(1);
    chk("t2_valid", val_v, 1);
    chk("t2_data", data_v, 4'b1010);
    tick(3);
    chk("t2_one_word", val_v, 0);
    // backpressure with two words and surplus samples
    rdy_v = 0;
    qv.push_back(4'b1100);
    qv.push_back(4'b0110);
    vnb(1); vnb(1); vnb(0); vnb(0);
    vnb(0); vnb(1); vnb(1); vnb(0);
    vnb(1); vnb(1); vnb(1); vnb(1);
    chk("t3_first_valid", val_v, 1);
    chk("t3_first_data", data_v, 4'b1100);
    tick(2);
    rdy_v = 1;
    tick(1);
    rdy_v = 0;
    chk("t3_no_bubble", val_v, 1);
    chk("t3_second_data", data_v, 4'b0110);
    tick(2);
    rdy_v = 1;
    tick(2);
    rdy_v = 0;
    tick(4);
    chk("t3_drained", val_v, 0);
    // asynchronous reset mid-word
    qv.push_back(4'b1001);
    vnb(1); vnb(0); vnb(0); vnb(1);
    tick(1);
    chk("t1_pre_valid", val_v, 1);
    vnb(1); vnb(1);
    reset = 0;
    #1;
    chk("t1_async_valid", val_v, 0);
    chk("t1_async_data", data_v, 0);
    chk("t1_async_stuck", stk_v, 0);
    qv.delete(); qr.delete();
    tick(2);
    reset = 1;
    tick(1);
    qv.push_back(4'b0011);
    vnb(0); vnb(0); vnb(1); vnb(1);
    tick(1);
    chk("t1_fresh_valid", val_v, 1);
    chk("t1_fresh_data", data_v, 4'b0011);
    rdy_v = 1;
    tick(2);
    rdy_v = 0;
    chk("t1_drained", val_v, 0);
    // raw mode and handshake coinciding with a completed word
    qr.push_back(4'b1101);
    qr.push_back(4'b0110);
    s5 = 8'b1101_0110;
    for (int i = 7; i >= 4; i--) samp_r(s5[i]);
    chk("t5_latency_early", val_r, 0);
    samp_r(s5[3]);
    chk("t5_valid", val_r, 1);
    chk("t5_data", data_r, 4'b1101);
    for (int i = 2; i >= 0; i--) samp_r(s5[i]);
    rdy_r = 1;
    tick(1);
    rdy_r = 0;
    chk("t6_valid_kept", val_r, 1);
    chk("t6_data", data_r, 4'b0110);
    rdy_r = 1;
    tick(2);
    rdy_r = 0;
    chk("t6_drained", val_r, 0);
    // repetition health alarm
    reset = 0;
    tick(1);
    reset = 1;
    tick(1);
    rdy_v = 1;
    repeat (7) samp_v(1);
    chk("t4_not_yet", stk_v, 0);
    samp_v(1);
    tick(1);
    chk("t4_stuck", stk_v, 1);
    chk("t4_no_word", val_v, 0);
    vnb(1); vnb(0); vnb(1); vnb(0);
    tick(3);
    chk("t4_sticky", stk_v, 1);
    chk("t4_silent", val_v, 0);
    chk("q_empty_v", qv.size(), 0);
    chk("q_empty_r", qr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
